// File: rtl/addsub_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_pkg
//  Description : Shared constants, state encoding and helpers for the
//                nibble-serial add/subtract sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package addsub_pkg;

    // Width of the shared ripple-carry slice.
    localparam int SLICE_W = 4;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of slice passes needed for a full-width operation.
    function automatic int nslices(input int width);
        return width / SLICE_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rca_nbit.sv
`default_nettype none
// ============================================================================
//  Module      : rca_nbit
//  Description : N-bit ripple-carry adder; the controller time-shares one
//                4-bit instance across all nibbles of an operation.
//  Revision    : 1.0 - initial release
// ============================================================================
module rca_nbit #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[N];

endmodule
`default_nettype wire

// File: rtl/addsub_serial_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_serial_ctrl
//  Description : Nibble-serial WIDTH-bit add/subtract sequencer built around a
//                single shared 4-bit ripple-carry slice.
//                Optional macro ADDSUB_OVF_EN adds a signed overflow output.
//  Revision    : 1.0 - initial release
// ============================================================================
module addsub_serial_ctrl
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             add_n,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c_out
`ifdef ADDSUB_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int               NSLICES  = nslices(WIDTH);
    localparam int               IDX_W    = (NSLICES > 1) ? $clog2(NSLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICES - 1);

    if (((WIDTH % SLICE_W) != 0) || (WIDTH < 8)) begin : g_bad_width
        $error("addsub_serial_ctrl: WIDTH must be a multiple of 4 and at least 8");
    end

    state_t               state;
    logic [IDX_W-1:0]     idx;
    logic                 carry;
    logic                 op_q;
    logic [WIDTH-1:0]     x_q;
    logic [WIDTH-1:0]     y_q;
    // The top nibble is never stored: it goes straight into s at commit.
    logic [WIDTH-SLICE_W-1:0] partial;

    logic [SLICE_W-1:0]   slice_a;
    logic [SLICE_W-1:0]   slice_b;
    logic [SLICE_W-1:0]   slice_sum;
    logic                 slice_cout;

    // Subtraction feeds ~y into the slice; the +1 arrives as the initial carry.
    assign slice_a = x_q[SLICE_W*idx +: SLICE_W];
    assign slice_b = y_q[SLICE_W*idx +: SLICE_W] ^ {SLICE_W{op_q}};

    rca_nbit #(
        .N    (SLICE_W)
    ) u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    assign ready = (state == IDLE);
    assign done  = (state == DONE);

    // Sequencer: accept, walk the nibbles through the slice, commit.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            idx     <= '0;
            carry   <= 1'b0;
            op_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            partial <= '0;
            s       <= '0;
            c_out   <= 1'b0;
`ifdef ADDSUB_OVF_EN
            overflow <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        x_q   <= x;
                        y_q   <= y;
                        op_q  <= add_n;
                        carry <= add_n;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    carry <= slice_cout;
                    if (idx == LAST_IDX) begin
                        s     <= {slice_sum, partial};
                        c_out <= slice_cout;
`ifdef ADDSUB_OVF_EN
                        // Signed overflow: like-signed operands, result sign differs.
                        overflow <= (x_q[WIDTH-1] == (y_q[WIDTH-1] ^ op_q)) &&
                                    (slice_sum[SLICE_W-1] != x_q[WIDTH-1]);
`endif
                        idx   <= '0;
                        state <= DONE;
                    end else begin
                        partial[SLICE_W*idx +: SLICE_W] <= slice_sum;
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_addsub_serial_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_addsub_serial_ctrl
//  Description : Self-checking bench for addsub_serial_ctrl (WIDTH=16):
//                directed cases, randomized operations, ignored start
//                requests, and mid-operation reset, against an arithmetic
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_addsub_serial_ctrl;

    localparam int WIDTH = 16;
    localparam int NSL   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic             add_n;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             c_out;
`ifdef ADDSUB_OVF_EN
    logic             overflow;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [WIDTH-1:0] last_s;
    logic             last_c;
    logic             last_ovf;

    always #5 clk = ~clk;

    addsub_serial_ctrl #(
        .WIDTH    (WIDTH)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .add_n    (add_n),
        .x        (x),
        .y        (y),
        .ready    (ready),
        .done     (done),
        .s        (s),
        .c_out    (c_out)
`ifdef ADDSUB_OVF_EN
        ,
        .overflow (overflow)
`endif
    );

    // Single comparison point: counts every check, reports mismatches.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference: {overflow, carry, sum} from plain integer arithmetic.
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic op);
        longint ua, ub, full, sa, sb, r, half, span;
        logic   c, ov;
        logic [WIDTH-1:0] sum;
        ua   = longint'(a);
        ub   = longint'(b);
        span = longint'(1) << WIDTH;
        half = span / 2;
        if (!op) begin
            full = ua + ub;
            c    = (full >= span);
        end else begin
            full = ua - ub;
            c    = (ua >= ub);
        end
        sum = WIDTH'(full);
        sa  = (ua >= half) ? ua - span : ua;
        sb  = (ub >= half) ? ub - span : ub;
        r   = op ? (sa - sb) : (sa + sb);
        ov  = (r >= half) || (r < -half);
        return {ov, c, sum};
    endfunction

    // One operation issued from IDLE (#1 after an edge); poke drives start
    // during RUN and DONE, which must be ignored.
    task automatic run_op(input logic [WIDTH-1:0] ox, input logic [WIDTH-1:0] oy,
                          input logic op, input bit poke);
        logic [WIDTH+1:0] e;
        e = model(ox, oy, op);
        check("ready_idle", 32'(ready), 32'd1);
        start = 1'b1; add_n = op; x = ox; y = oy;
        @(posedge clk); #1;
        start = 1'b0;
        x = WIDTH'($urandom); y = WIDTH'($urandom); add_n = 1'($urandom);
        for (int k = 0; k < NSL; k++) begin
            check("ready_run", 32'(ready), 32'd0);
            check("done_run", 32'(done), 32'd0);
            check("s_hold", 32'(s), 32'(last_s));
            check("c_hold", 32'(c_out), 32'(last_c));
            if (poke) begin
                start = 1'b1; x = WIDTH'($urandom); y = WIDTH'($urandom); add_n = 1'($urandom);
            end
            @(posedge clk); #1;
        end
        check("done_pulse", 32'(done), 32'd1);
        check("ready_done", 32'(ready), 32'd0);
        check("sum", 32'(s), 32'(e[WIDTH-1:0]));
        check("carry", 32'(c_out), 32'(e[WIDTH]));
`ifdef ADDSUB_OVF_EN
        check("ovf", 32'(overflow), 32'(e[WIDTH+1]));
`endif
        last_s = e[WIDTH-1:0]; last_c = e[WIDTH]; last_ovf = e[WIDTH+1];
        if (poke) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("done_clear", 32'(done), 32'd0);
        check("ready_back", 32'(ready), 32'd1);
        check("s_after", 32'(s), 32'(last_s));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; add_n = 1'b0; x = '0; y = '0;
        last_s = '0; last_c = 1'b0; last_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_s", 32'(s), 32'd0);
        check("rst_c", 32'(c_out), 32'd0);
`ifdef ADDSUB_OVF_EN
        check("rst_ovf", 32'(overflow), 32'd0);
`endif
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases, issued back to back.
        run_op(16'h1234, 16'h0FCD, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run_op(16'h0005, 16'h0007, 1'b1, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b1, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        run_op(16'h1234, 16'h1234, 1'b1, 1'b0);
        run_op(16'h0001, 16'h0001, 1'b0, 1'b1);

        // Mid-operation reset: abandoned run, outputs cleared, no done.
        check("pre_rst_s", 32'(s != '0), 32'd1);
        start = 1'b1; add_n = 1'b0; x = 16'hABCD; y = 16'h1111;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        last_s = '0; last_c = 1'b0; last_ovf = 1'b0;
        check("mid_rst_ready", 32'(ready), 32'd1);
        check("mid_rst_s", 32'(s), 32'd0);
        check("mid_rst_c", 32'(c_out), 32'd0);
        for (int k = 0; k < NSL + 2; k++) begin
            check("mid_rst_nodone", 32'(done), 32'd0);
            @(posedge clk); #1;
        end
        run_op(16'h4321, 16'h1234, 1'b1, 1'b0);

        // Randomized operations, some with ignored start requests.
        for (int i = 0; i < 40; i++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
